// File: rtl/rotate_detector.sv
// Finds the smallest left-rotate amount k that maps a captured word onto a
// captured target, stepping one rotation per cycle; result held until consumed.
module rotate_detector #(
  parameter int BW_DATA = 8,
  parameter int BW_CTRL = $clog2(BW_DATA)
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic [BW_DATA-1:0] i_a,
  input  logic [BW_DATA-1:0] i_y,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  output logic [BW_CTRL-1:0] o_k,
  output logic               o_found,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic               o_busy,
  output logic [1:0]         o_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid, once raised, stays high with its data stable until then.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [BW_CTRL-1:0] CNT_LAST = BW_CTRL'(BW_DATA - 1);

  state_t             state;
  logic [BW_DATA-1:0] rot;
  logic [BW_DATA-1:0] target;
  logic [BW_CTRL-1:0] cnt;

  assign o_state = state;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= IDLE;
      rot         <= '0;
      target      <= '0;
      cnt         <= '0;
      o_k         <= '0;
      o_found     <= 1'b0;
      o_out_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (i_in_valid && o_in_ready) begin
            rot        <= i_a;
            target     <= i_y;
            cnt        <= '0;
            o_in_ready <= 1'b0;
            o_busy     <= 1'b1;
            state      <= SEARCH;
          end
        end
        SEARCH: begin
          // rot always equals the captured word rotated left by cnt
          if (rot == target) begin
            o_k         <= cnt;
            o_found     <= 1'b1;
            o_busy      <= 1'b0;
            o_out_valid <= 1'b1;
            state       <= DONE;
          end else if (cnt == CNT_LAST) begin
            o_k         <= '0;
            o_found     <= 1'b0;
            o_busy      <= 1'b0;
            o_out_valid <= 1'b1;
            state       <= DONE;
          end else begin
            rot <= {rot[BW_DATA-2:0], rot[BW_DATA-1]};
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (i_out_ready) begin
            o_out_valid <= 1'b0;
            o_in_ready  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rotate_detector.sv
// Bench for rotate_detector: directed cases plus random rotations, compared each
// cycle against a transaction-level model of the search result and its timing.
module tb_rotate_detector;

  localparam int W  = 8;
  localparam int CW = 3;

  logic          i_clk;
  logic          i_rstn;
  logic [W-1:0]  i_a;
  logic [W-1:0]  i_y;
  logic          i_in_valid;
  logic          o_in_ready;
  logic [CW-1:0] o_k;
  logic          o_found;
  logic          o_out_valid;
  logic          i_out_ready;
  logic          o_busy;
  logic [1:0]    o_state;

  int n_checks = 0;
  int n_fail   = 0;

  rotate_detector #(.BW_DATA(W), .BW_CTRL(CW)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_a(i_a), .i_y(i_y),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .o_k(o_k),
    .o_found(o_found), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_busy(o_busy), .o_state(o_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference arithmetic
  function automatic logic [W-1:0] rotl(input logic [W-1:0] a, input int k);
    logic [W-1:0] r;
    r = (a << k) | (a >> (W - k));
    return r;
  endfunction

  function automatic logic [W-1:0] rotr(input logic [W-1:0] a, input int k);
    logic [W-1:0] r;
    r = (a >> k) | (a << (W - k));
    return r;
  endfunction

  function automatic int find_k(input logic [W-1:0] a, input logic [W-1:0] y);
    for (int k = 0; k < W; k++)
      if (rotl(a, k) == y) return k;
    return -1;
  endfunction

  // transaction model: one outstanding request, result visible after its latency
  logic m_pending;
  int   m_left;
  int   m_k;
  logic m_found;

  always @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      m_pending <= 1'b0;
      m_left    <= 0;
      m_k       <= 0;
      m_found   <= 1'b0;
    end else if (m_pending) begin
      if (m_left > 0) m_left <= m_left - 1;
      else if (i_out_ready) m_pending <= 1'b0;
    end else if (i_in_valid) begin
      m_pending <= 1'b1;
      m_found   <= (find_k(i_a, i_y) >= 0);
      m_k       <= (find_k(i_a, i_y) >= 0) ? find_k(i_a, i_y) : 0;
      m_left    <= (find_k(i_a, i_y) >= 0) ? find_k(i_a, i_y) + 1 : W;
    end
  end

  // per-cycle compare against the model
  always @(negedge i_clk) begin
    check("in_ready", o_in_ready, !m_pending);
    check("busy", o_busy, m_pending && (m_left > 0));
    check("out_valid", o_out_valid, m_pending && (m_left == 0));
    if (m_pending && (m_left == 0)) begin
      check("k", o_k, m_k);
      check("found", o_found, m_found);
    end
  end

  // driver: issue one request, measure latency, optionally stall the consumer
  task automatic run_req(input logic [W-1:0] a, input logic [W-1:0] y, input int stall,
                         output int k, output int found, output int lat);
    int guard;
    guard = 0;
    while (!o_in_ready && guard < 20) begin
      @(negedge i_clk);
      guard++;
    end
    check("in_ready_before_req", o_in_ready, 1);
    i_a = a;
    i_y = y;
    i_in_valid  = 1'b1;
    i_out_ready = (stall == 0);
    @(posedge i_clk);
    #1;
    i_in_valid = 1'b0;
    i_a = W'($urandom);
    i_y = W'($urandom);
    check("busy_after_accept", o_busy, 1);
    lat = 0;
    while (!o_out_valid && lat < 20) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
    if (lat >= 20) check("result_timeout", 0, 1);
    k = o_k;
    found = o_found;
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        @(negedge i_clk);
        i_in_valid = 1'b1;
        i_a = W'($urandom);
        i_y = W'($urandom);
        check("k_held", o_k, k);
        check("found_held", o_found, found);
        check("in_ready_in_done", o_in_ready, 0);
      end
      @(negedge i_clk);
      i_in_valid  = 1'b0;
      i_out_ready = 1'b1;
    end
    @(posedge i_clk);
    #1;
    check("valid_drop", o_out_valid, 0);
    check("ready_return", o_in_ready, 1);
  endtask

  initial begin
    int k, f, lat, kk, kl, per, exp_k;
    logic left;
    logic [W-1:0] a, y;

    i_rstn = 1'b1;
    i_a = '0;
    i_y = '0;
    i_in_valid  = 1'b0;
    i_out_ready = 1'b1;
    #1 i_rstn = 1'b0;
    #3;
    check("rst_in_ready", o_in_ready, 1);
    check("rst_out_valid", o_out_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_k", o_k, 0);
    check("rst_found", o_found, 0);
    @(negedge i_clk);
    i_rstn = 1'b1;

    // pin the model itself with hand-computed answers
    check("model_96_b4", find_k(8'h96, 8'hB4), 3);
    check("model_55_aa", find_k(8'h55, 8'hAA), 1);
    check("model_01_03", find_k(8'h01, 8'h03), -1);

    run_req(8'h96, 8'hB4, 0, k, f, lat);
    check("d96_k", k, 3); check("d96_found", f, 1); check("d96_lat", lat, 4);
    run_req(8'h55, 8'hAA, 0, k, f, lat);
    check("d55_k", k, 1); check("d55_found", f, 1); check("d55_lat", lat, 2);
    run_req(8'hFF, 8'hFF, 0, k, f, lat);
    check("dff_k", k, 0); check("dff_found", f, 1); check("dff_lat", lat, 1);
    run_req(8'h01, 8'h03, 0, k, f, lat);
    check("d01_k", k, 0); check("d01_found", f, 0); check("d01_lat", lat, 8);
    run_req(8'h96, 8'hB4, 5, k, f, lat);
    check("stall_k", k, 3); check("stall_found", f, 1);

    // reset mid-search abandons the request
    @(negedge i_clk);
    i_a = 8'h96; i_y = 8'hB4; i_in_valid = 1'b1; i_out_ready = 1'b1;
    @(posedge i_clk);
    #1 i_in_valid = 1'b0;
    @(posedge i_clk);
    @(posedge i_clk);
    #2 i_rstn = 1'b0;
    #1;
    check("midrst_in_ready", o_in_ready, 1);
    check("midrst_out_valid", o_out_valid, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_k", o_k, 0);
    check("midrst_found", o_found, 0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge i_clk);
      #1 check("no_result_after_rst", o_out_valid, 0);
    end

    // random rotations, expected k derived from the rotation that built i_y
    for (int i = 0; i < 30; i++) begin
      a = W'($urandom);
      if (i % 5 == 0) a = {a[3:0], a[3:0]};
      kk = $urandom_range(0, W - 1);
      left = 1'($urandom_range(0, 1));
      y = left ? rotl(a, kk) : rotr(a, kk);
      kl = left ? kk : (W - kk) % W;
      per = W;
      for (int p = W; p >= 1; p--)
        if (rotl(a, p) == a) per = p;
      exp_k = kl % per;
      run_req(a, y, $urandom_range(0, 2), k, f, lat);
      check("rnd_found", f, 1);
      check("rnd_k", k, exp_k);
      check("rnd_lat", lat, exp_k + 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
